// File: rtl/m_s_int_ctrl_if.sv
// CSR access and trap-unit handshake bundle for the M/S interrupt controller.
// The controller takes the slave side; the CSR file / trap unit drives the master side.
interface m_s_int_ctrl_if #(
  parameter int XLEN = 64
);
  logic            csr_write;
  logic            mrw_mie_sel;
  logic            srw_sie_sel;
  logic            mrw_mip_sel;
  logic            srw_sip_sel;
  logic            mrw_mideleg_sel;
  logic [XLEN-1:0] data_csr;
  logic [XLEN-1:0] mie_rdata;
  logic [XLEN-1:0] sie_rdata;
  logic [XLEN-1:0] mip_rdata;
  logic [XLEN-1:0] sip_rdata;
  logic [XLEN-1:0] mideleg_rdata;
  logic            int_req;
  logic [3:0]      int_cause;
  logic            int_to_s;
  logic            int_ack;

  modport master (
    output csr_write, mrw_mie_sel, srw_sie_sel, mrw_mip_sel, srw_sip_sel, mrw_mideleg_sel,
    output data_csr, int_ack,
    input  mie_rdata, sie_rdata, mip_rdata, sip_rdata, mideleg_rdata,
    input  int_req, int_cause, int_to_s
  );

  modport slave (
    input  csr_write, mrw_mie_sel, srw_sie_sel, mrw_mip_sel, srw_sip_sel, mrw_mideleg_sel,
    input  data_csr, int_ack,
    output mie_rdata, sie_rdata, mip_rdata, sip_rdata, mideleg_rdata,
    output int_req, int_cause, int_to_s
  );
endinterface

// File: rtl/m_s_int_ctrl.sv
// M/S interrupt controller: mie/mip/mideleg state, pin synchronisers, priority pick
// and a registered req/ack handshake towards the trap unit.
module m_s_int_ctrl #(
  parameter int XLEN        = 64,
  parameter int SYNC_STAGES = 2,
  parameter bit HAS_S       = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m_ext_int,
  input  logic           s_ext_int,
  input  logic           m_tim_int,
  input  logic           m_soft_int,
  input  logic [1:0]     priv,
  input  logic           mstatus_mie,
  input  logic           mstatus_sie,
  m_s_int_ctrl_if.slave  bus
);

  localparam logic [11:0] MIE_MASK   = 12'hAAA;
  localparam logic [11:0] DELEG_MASK = 12'h222;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Pin order inside the synchroniser: {MEI, SEI, MTI, MSI}
  function automatic logic [11:0] mip_view(input logic [3:0] pins, input logic sw_seip,
                                           input logic stip, input logic ssip);
    return {pins[3], 1'b0, sw_seip | pins[2], 1'b0, pins[1], 1'b0,
            stip, 1'b0, pins[0], 1'b0, ssip, 1'b0};
  endfunction

  // Returns {valid, cause}; order MEI > MSI > MTI > SEI > SSI > STI
  function automatic logic [4:0] pick(input logic [11:0] v);
    if (v[11])     return {1'b1, 4'd11};
    else if (v[3]) return {1'b1, 4'd3};
    else if (v[7]) return {1'b1, 4'd7};
    else if (v[9]) return {1'b1, 4'd9};
    else if (v[1]) return {1'b1, 4'd1};
    else if (v[5]) return {1'b1, 4'd5};
    else           return {1'b0, 4'd0};
  endfunction

  logic [3:0]  sync_q [SYNC_STAGES];
  logic [3:0]  sync_s;
  logic [11:0] mie_q, mie_d, mideleg_q, mideleg_d;
  logic        sw_seip_q, sw_seip_d, stip_q, stip_d, ssip_q, ssip_d;
  logic        m_wr_s, s_wr_s;
  logic [11:0] wdata_s, mip_rd_s, mip_eval_s, pend_s;
  logic [4:0]  nd_pick_s, dl_pick_s;
  logic        m_en_s, s_en_s, sel_valid_s, sel_to_s_s, frozen_ok_s;
  logic [3:0]  sel_cause_s;
  state_e      state_q;
  logic        int_req_q, int_to_s_q;
  logic [3:0]  int_cause_q;
  logic        csr_unused_s;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign wdata_s      = bus.data_csr[11:0];
  assign csr_unused_s = ^bus.data_csr[XLEN-1:12];

  // CSR next-state; M-level selects suppress any simultaneous S-level write
  always_comb begin
    m_wr_s    = bus.csr_write & (bus.mrw_mie_sel | bus.mrw_mip_sel | bus.mrw_mideleg_sel);
    s_wr_s    = bus.csr_write & ~m_wr_s & HAS_S;
    mie_d     = mie_q;
    mideleg_d = mideleg_q;
    sw_seip_d = sw_seip_q;
    stip_d    = stip_q;
    ssip_d    = ssip_q;
    if (m_wr_s && bus.mrw_mie_sel) begin
      mie_d = wdata_s & MIE_MASK;
    end else if (s_wr_s && bus.srw_sie_sel) begin
      mie_d = (mie_q & ~mideleg_q) | (wdata_s & mideleg_q);
    end else begin
      mie_d = mie_q;
    end
    if (m_wr_s && bus.mrw_mideleg_sel && HAS_S) begin
      mideleg_d = wdata_s & DELEG_MASK;
    end else begin
      mideleg_d = mideleg_q;
    end
    if (m_wr_s && bus.mrw_mip_sel) begin
      sw_seip_d = wdata_s[9];
      stip_d    = wdata_s[5];
      ssip_d    = wdata_s[1];
    end else if (s_wr_s && bus.srw_sip_sel && mideleg_q[1]) begin
      ssip_d    = wdata_s[1];
    end else begin
      ssip_d    = ssip_q;
    end
  end

  // Selection runs on post-write CSR state so writes reach int_req in one register
  always_comb begin
    mip_eval_s  = mip_view(sync_s, sw_seip_d, stip_d, ssip_d);
    pend_s      = mip_eval_s & mie_d;
    m_en_s      = (priv != 2'd3) | mstatus_mie;
    s_en_s      = (priv == 2'd0) | ((priv == 2'd1) & mstatus_sie);
    nd_pick_s   = pick(pend_s & ~mideleg_d);
    dl_pick_s   = pick(pend_s & mideleg_d);
    sel_valid_s = 1'b0;
    sel_cause_s = 4'd0;
    sel_to_s_s  = 1'b0;
    if (m_en_s && nd_pick_s[4]) begin
      sel_valid_s = 1'b1;
      sel_cause_s = nd_pick_s[3:0];
      sel_to_s_s  = 1'b0;
    end else if (s_en_s && dl_pick_s[4]) begin
      sel_valid_s = 1'b1;
      sel_cause_s = dl_pick_s[3:0];
      sel_to_s_s  = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
    end
    frozen_ok_s = pend_s[int_cause_q] && (mideleg_d[int_cause_q] == int_to_s_q) &&
                  (int_to_s_q ? s_en_s : m_en_s);
  end

  // Interrupt pin synchroniser chains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'd0;
    end else begin
      sync_q[0] <= {m_ext_int, s_ext_int, m_tim_int, m_soft_int};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // CSR state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q     <= 12'd0;
      mideleg_q <= 12'd0;
      sw_seip_q <= 1'b0;
      stip_q    <= 1'b0;
      ssip_q    <= 1'b0;
    end else begin
      mie_q     <= mie_d;
      mideleg_q <= mideleg_d;
      sw_seip_q <= sw_seip_d;
      stip_q    <= stip_d;
      ssip_q    <= ssip_d;
    end
  end

  // Request handshake FSM; cause and target stay frozen while in REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      int_req_q   <= 1'b0;
      int_cause_q <= 4'd0;
      int_to_s_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_valid_s) begin
            state_q     <= ST_REQ;
            int_req_q   <= 1'b1;
            int_cause_q <= sel_cause_s;
            int_to_s_q  <= sel_to_s_s;
          end else begin
            int_req_q   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.int_ack) begin
            state_q   <= ST_GAP;
            int_req_q <= 1'b0;
          end else if (!frozen_ok_s) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
          end else begin
            int_req_q <= 1'b1;
          end
        end
        ST_GAP: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mip_rd_s          = mip_view(sync_s, sw_seip_q, stip_q, ssip_q);
  assign bus.mie_rdata     = {{(XLEN-12){1'b0}}, mie_q};
  assign bus.sie_rdata     = {{(XLEN-12){1'b0}}, mie_q & mideleg_q};
  assign bus.mip_rdata     = {{(XLEN-12){1'b0}}, mip_rd_s};
  assign bus.sip_rdata     = {{(XLEN-12){1'b0}}, mip_rd_s & mideleg_q};
  assign bus.mideleg_rdata = {{(XLEN-12){1'b0}}, mideleg_q};
  assign bus.int_req       = int_req_q;
  assign bus.int_cause     = int_cause_q;
  assign bus.int_to_s      = int_to_s_q;

endmodule

// File: tb/tb_m_s_int_ctrl.sv
// Directed bench for m_s_int_ctrl: timer path, priority, delegation, masked views,
// withdraw and asynchronous reset, all against hand-computed values.
module tb_m_s_int_ctrl;

  localparam int SEL_MIE = 0, SEL_SIE = 1, SEL_MIP = 2, SEL_SIP = 3, SEL_DELEG = 4;

  logic       clk;
  logic       rst;
  logic       m_ext_int, s_ext_int, m_tim_int, m_soft_int;
  logic [1:0] priv;
  logic       mstatus_mie, mstatus_sie;
  int         n_checks;
  int         n_errors;

  m_s_int_ctrl_if #(.XLEN(64)) bus ();

  m_s_int_ctrl #(.XLEN(64), .SYNC_STAGES(2), .HAS_S(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_ext_int   (m_ext_int),
    .s_ext_int   (s_ext_int),
    .m_tim_int   (m_tim_int),
    .m_soft_int  (m_soft_int),
    .priv        (priv),
    .mstatus_mie (mstatus_mie),
    .mstatus_sie (mstatus_sie),
    .bus         (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input int which, input logic [63:0] d);
    bus.csr_write       = 1'b1;
    bus.data_csr        = d;
    bus.mrw_mie_sel     = (which == SEL_MIE);
    bus.srw_sie_sel     = (which == SEL_SIE);
    bus.mrw_mip_sel     = (which == SEL_MIP);
    bus.srw_sip_sel     = (which == SEL_SIP);
    bus.mrw_mideleg_sel = (which == SEL_DELEG);
    tick();
    bus.csr_write       = 1'b0;
    bus.mrw_mie_sel     = 1'b0;
    bus.srw_sie_sel     = 1'b0;
    bus.mrw_mip_sel     = 1'b0;
    bus.srw_sip_sel     = 1'b0;
    bus.mrw_mideleg_sel = 1'b0;
    bus.data_csr        = 64'd0;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [3:0] cause,
                           input logic to_s);
    check_val({tag, "_req"}, {63'd0, bus.int_req}, {63'd0, req});
    if (req) begin
      check_val({tag, "_cause"}, {60'd0, bus.int_cause}, {60'd0, cause});
      check_val({tag, "_to_s"}, {63'd0, bus.int_to_s}, {63'd0, to_s});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    {m_ext_int, s_ext_int, m_tim_int, m_soft_int} = 4'd0;
    priv = 2'd3;
    mstatus_mie = 1'b0;
    mstatus_sie = 1'b0;
    bus.csr_write = 1'b0;
    bus.mrw_mie_sel = 1'b0;
    bus.srw_sie_sel = 1'b0;
    bus.mrw_mip_sel = 1'b0;
    bus.srw_sip_sel = 1'b0;
    bus.mrw_mideleg_sel = 1'b0;
    bus.data_csr = 64'd0;
    bus.int_ack = 1'b0;

    #2;
    check_val("rst_req", {63'd0, bus.int_req}, 64'd0);
    check_val("rst_cause", {60'd0, bus.int_cause}, 64'd0);
    check_val("rst_mie", bus.mie_rdata, 64'd0);
    check_val("rst_mip", bus.mip_rdata, 64'd0);
    tick();
    tick();
    rst = 1'b1;

    // Timer in M: pin -> req in SYNC_STAGES+1 cycles
    mstatus_mie = 1'b1;
    csr_wr(SEL_MIE, 64'h080);
    check_val("tim_mie", bus.mie_rdata, 64'h080);
    m_tim_int = 1'b1;
    tick();
    tick();
    check_val("tim_mip", bus.mip_rdata, 64'h080);
    check_req("tim_early", 1'b0, 4'd0, 1'b0);
    tick();
    check_req("tim", 1'b1, 4'd7, 1'b0);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check_req("tim_gap", 1'b0, 4'd0, 1'b0);
    tick();
    check_req("tim_idle", 1'b0, 4'd0, 1'b0);
    tick();
    check_req("tim_again", 1'b1, 4'd7, 1'b0);

    // Withdraw by clearing mie, then a stray ack is ignored
    csr_wr(SEL_MIE, 64'h0);
    check_req("wd_fall", 1'b0, 4'd0, 1'b0);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check_req("wd_ack", 1'b0, 4'd0, 1'b0);
    m_tim_int = 1'b0;
    tick();
    tick();
    tick();

    // Priority: MEI beats MSI beats SSI
    priv = 2'd0;
    m_ext_int = 1'b1;
    m_soft_int = 1'b1;
    csr_wr(SEL_MIP, 64'h002);
    tick();
    check_val("pri_mip", bus.mip_rdata, 64'h80A);
    csr_wr(SEL_MIE, 64'hAAA);
    check_req("pri_mei", 1'b1, 4'd11, 1'b0);
    bus.int_ack = 1'b1;
    m_ext_int = 1'b0;
    tick();
    bus.int_ack = 1'b0;
    check_req("pri_gap", 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    check_req("pri_msi", 1'b1, 4'd3, 1'b0);
    csr_wr(SEL_MIE, 64'h0);
    m_soft_int = 1'b0;
    csr_wr(SEL_MIP, 64'h0);
    tick();
    tick();

    // Delegation: SSIP held off in M, taken in S
    priv = 2'd3;
    csr_wr(SEL_DELEG, 64'h222);
    check_val("dlg_mideleg", bus.mideleg_rdata, 64'h222);
    csr_wr(SEL_MIE, 64'h222);
    csr_wr(SEL_MIP, 64'h002);
    check_req("dlg_in_m", 1'b0, 4'd0, 1'b0);
    check_val("dlg_sip", bus.sip_rdata, 64'h002);
    check_val("dlg_sie", bus.sie_rdata, 64'h222);
    priv = 2'd1;
    mstatus_sie = 1'b1;
    tick();
    check_req("dlg_in_s", 1'b1, 4'd1, 1'b1);
    priv = 2'd3;
    tick();
    check_req("dlg_back_m", 1'b0, 4'd0, 1'b0);
    csr_wr(SEL_MIP, 64'h0);
    csr_wr(SEL_MIE, 64'h0);

    // Masked views through sie/sip
    csr_wr(SEL_DELEG, 64'h020);
    csr_wr(SEL_SIE, 64'h222);
    check_val("mv_mie", bus.mie_rdata, 64'h020);
    check_val("mv_sie", bus.sie_rdata, 64'h020);
    csr_wr(SEL_SIP, 64'h002);
    check_val("mv_sip_blk", bus.mip_rdata, 64'h0);
    csr_wr(SEL_DELEG, 64'hFFF);
    check_val("mv_deleg_mask", bus.mideleg_rdata, 64'h222);
    csr_wr(SEL_SIP, 64'h002);
    check_val("mv_sip_ok", bus.mip_rdata, 64'h002);
    csr_wr(SEL_MIE, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("mv_mie_mask", bus.mie_rdata, 64'hAAA);
    check_val("mv_sie_all", bus.sie_rdata, 64'h222);
    check_req("mv_no_req", 1'b0, 4'd0, 1'b0);

    // Async reset in the middle of REQ
    priv = 2'd0;
    tick();
    check_req("ar_pre", 1'b1, 4'd1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("ar_req", {63'd0, bus.int_req}, 64'd0);
    check_val("ar_cause", {60'd0, bus.int_cause}, 64'd0);
    check_val("ar_to_s", {63'd0, bus.int_to_s}, 64'd0);
    check_val("ar_mie", bus.mie_rdata, 64'd0);
    check_val("ar_mip", bus.mip_rdata, 64'd0);
    check_val("ar_deleg", bus.mideleg_rdata, 64'd0);
    check_val("ar_sie", bus.sie_rdata, 64'd0);
    check_val("ar_sip", bus.sip_rdata, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
